// File: rtl/ct_split_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ct_pkg
// Brief    : Shared widths and flow-to-output-mask lookup for the split node.
// Revision : 1.0 - initial release
// ============================================================================
package ct_pkg;

    localparam int c_WF_DEFAULT  = 4;
    localparam int c_WO_DEFAULT  = 32;

    // Upper bounds for the lookup vectors; callers zero-extend into these.
    localparam int c_MAX_NO      = 64;
    localparam int c_MAX_NF      = 64;
    localparam int c_MAX_WF      = 32;
    localparam int c_MAX_FLOWS_W = c_MAX_NF * c_MAX_WF;
    localparam int c_MAX_EN_W    = c_MAX_NF * c_MAX_NO;

    // Duplicate flow IDs simply OR their output masks together.
    function automatic logic [c_MAX_NO-1:0] ct_flow_lookup(
        input logic [c_MAX_FLOWS_W-1:0] flows,
        input logic [c_MAX_EN_W-1:0]    enables,
        input logic [c_MAX_WF-1:0]      flow,
        input int                       nf,
        input int                       no,
        input int                       wf
    );
        logic [c_MAX_NO-1:0] w_mask;
        logic [c_MAX_NO-1:0] w_omask;
        logic [c_MAX_NO-1:0] w_en;
        logic [c_MAX_WF-1:0] w_fmask;
        logic [c_MAX_WF-1:0] w_fid;
        w_mask  = '0;
        w_fmask = (c_MAX_WF'(1) << wf) - c_MAX_WF'(1);
        w_omask = (c_MAX_NO'(1) << no) - c_MAX_NO'(1);
        for (int i = 0; i < c_MAX_NF; i++) begin
            if (i < nf) begin
                w_fid = c_MAX_WF'(flows >> (i * wf)) & w_fmask;
                w_en  = c_MAX_NO'(enables >> (i * no)) & w_omask;
                if (w_fid == (flow & w_fmask)) begin
                    w_mask = w_mask | w_en;
                end
            end
        end
        return w_mask;
    endfunction

endpackage : ct_pkg
`default_nettype wire

// File: rtl/ct_split_buf_out_slot.sv
`default_nettype none
// ============================================================================
// Module   : ct_out_slot
// Brief    : One-deep registered output stage with load/drain; load wins.
// Revision : 1.0 - initial release
// ============================================================================
module ct_out_slot
    import ct_pkg::*;
#(
    parameter int WO = c_WO_DEFAULT,
    parameter int WF = c_WF_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [WO-1:0] i_data,
    input  logic          i_eop,
    input  logic [WF-1:0] i_flow,
    input  logic          i_ready,
    output logic [WO-1:0] o_data,
    output logic          o_eop,
    output logic [WF-1:0] o_flow,
    output logic          o_full,
    output logic          o_empty
);

    logic          r_full;
    logic [WO-1:0] r_data;
    logic          r_eop;
    logic [WF-1:0] r_flow;

    // Load takes priority over drain so a draining slot can refill in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_eop  <= 1'b0;
            r_flow <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_eop  <= i_eop;
            r_flow <= i_flow;
        end else if (r_full && i_ready) begin
            r_full <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_eop   = r_eop;
    assign o_flow  = r_flow;
    assign o_full  = r_full;
    assign o_empty = ~r_full;

endmodule : ct_out_slot
`default_nettype wire

// File: rtl/ct_split_buf.sv
`default_nettype none
// ============================================================================
// Module   : ct_split_buf
// Brief    : Flow-routed registered split node with eager multicast fork.
//            Optional drop counter enabled by CT_SPLIT_BUF_DROP_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ct_split_buf
    import ct_pkg::*;
#(
    parameter int              NO      = 2,
    parameter int              WO      = c_WO_DEFAULT,
    parameter int              NF      = 1,
    parameter int              WF      = c_WF_DEFAULT,
    parameter logic [NF*WF-1:0] FLOWS   = '0,
    parameter logic [NF*NO-1:0] ENABLES = '0,
    parameter int              WC      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WO-1:0]    i_data,
    input  logic             i_valid,
    input  logic             i_eop,
    input  logic [WF-1:0]    i_flow,
    output logic             o_ready,
    output logic [NO*WO-1:0] o_data,
    output logic [NO-1:0]    o_valid,
    output logic [NO-1:0]    o_eop,
    output logic [NO*WF-1:0] o_flow,
    input  logic [NO-1:0]    i_ready,
    output logic [WC-1:0]    o_drop_count
);

    logic [NO-1:0] w_en;
    logic [NO-1:0] w_empty;
    logic [NO-1:0] w_slot_ok;
    logic [NO-1:0] w_load;
    logic          w_acc;
    logic          w_unmatched;

    assign w_en = NO'(ct_flow_lookup(c_MAX_FLOWS_W'(FLOWS), c_MAX_EN_W'(ENABLES),
                                     c_MAX_WF'(i_flow), NF, NO, WF));

    // Untargeted slots never hold back the input; i_valid stays out of o_ready.
    assign w_slot_ok   = ~w_en | w_empty | i_ready;
    assign o_ready     = &w_slot_ok;
    assign w_acc       = i_valid & o_ready;
    assign w_unmatched = (w_en == '0);
    assign w_load      = {NO{w_acc}} & w_en;

    generate
        for (genvar k = 0; k < NO; k++) begin : g_slot
            ct_out_slot #(
                .WO (WO),
                .WF (WF)
            ) u_slot (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_load[k]),
                .i_data  (i_data),
                .i_eop   (i_eop),
                .i_flow  (i_flow),
                .i_ready (i_ready[k]),
                .o_data  (o_data[k*WO +: WO]),
                .o_eop   (o_eop[k]),
                .o_flow  (o_flow[k*WF +: WF]),
                .o_full  (o_valid[k]),
                .o_empty (w_empty[k])
            );
        end
    endgenerate

`ifdef CT_SPLIT_BUF_DROP_COUNT_EN
    logic [WC-1:0] r_drop_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_acc && w_unmatched && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + WC'(1);
        end
    end

    assign o_drop_count = r_drop_count;
`else
    logic w_unused_unmatched;
    assign w_unused_unmatched = w_unmatched;
    assign o_drop_count       = '0;
`endif

endmodule : ct_split_buf
`default_nettype wire

// File: tb/tb_ct_split_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_split_buf
// Brief    : Self-checking bench with per-output queue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_split_buf;

    localparam int NO = 2;
    localparam int WO = 32;
    localparam int NF = 3;
    localparam int WF = 4;
    localparam int WC = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [WO-1:0]    i_data;
    logic             i_valid;
    logic             i_eop;
    logic [WF-1:0]    i_flow;
    logic             o_ready;
    logic [NO*WO-1:0] o_data;
    logic [NO-1:0]    o_valid;
    logic [NO-1:0]    o_eop;
    logic [NO*WF-1:0] o_flow;
    logic [NO-1:0]    i_ready;
    logic [WC-1:0]    o_drop_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [WO-1:0] d;
        logic          e;
        logic [WF-1:0] f;
    } beat_t;

    beat_t q[NO][$];
    int    drops = 0;

    ct_split_buf #(
        .NO      (NO),
        .WO      (WO),
        .NF      (NF),
        .WF      (WF),
        .FLOWS   ({4'd2, 4'd1, 4'd0}),
        .ENABLES ({2'b11, 2'b10, 2'b01}),
        .WC      (WC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_eop        (i_eop),
        .i_flow       (i_flow),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_eop        (o_eop),
        .o_flow       (o_flow),
        .i_ready      (i_ready),
        .o_drop_count (o_drop_count)
    );

    always #5 clk = ~clk;

    // Routing table: flow 0 -> out0, flow 1 -> out1, flow 2 -> both.
    function automatic logic [NO-1:0] exp_mask(input logic [WF-1:0] f);
        case (f)
            4'd0:    return 2'b01;
            4'd1:    return 2'b10;
            4'd2:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic exp_ready();
        logic [NO-1:0] m;
        m = exp_mask(i_flow);
        for (int k = 0; k < NO; k++) begin
            if (m[k] && q[k].size() != 0 && !i_ready[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [NO-1:0] exp_valid();
        logic [NO-1:0] v;
        for (int k = 0; k < NO; k++) v[k] = (q[k].size() != 0);
        return v;
    endfunction

    function automatic logic [WC-1:0] exp_drops();
`ifdef CT_SPLIT_BUF_DROP_COUNT_EN
        return (drops > 3) ? WC'(3) : WC'(drops);
`else
        return WC'(0);
`endif
    endfunction

    task automatic drive(input logic v, input logic [WF-1:0] f, input logic [WO-1:0] d,
                         input logic e, input logic [NO-1:0] r);
        i_valid = v;
        i_flow  = f;
        i_data  = d;
        i_eop   = e;
        i_ready = r;
        #1;
    endtask

    // Advance one clock and update the scoreboard from the inputs seen at the edge.
    task automatic tick();
        logic [NO-1:0] m;
        logic          acc;
        logic [NO-1:0] rdy;
        logic          rst_now;
        beat_t         b;
        m       = exp_mask(i_flow);
        acc     = i_valid && exp_ready();
        rdy     = i_ready;
        rst_now = reset;
        b       = '{d: i_data, e: i_eop, f: i_flow};
        @(posedge clk);
        if (!rst_now) begin
            for (int k = 0; k < NO; k++) begin
                if (q[k].size() != 0 && rdy[k]) void'(q[k].pop_front());
            end
            if (acc) begin
                if (m == '0) drops++;
                for (int k = 0; k < NO; k++) begin
                    if (m[k]) q[k].push_back(b);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 4'd0, 32'hDEAD, 1'b1, 2'b11);
        total++; if (o_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", o_valid); end
        total++; if (o_data !== '0 || o_eop !== '0 || o_flow !== '0) begin
            bad++; $display("FAIL reset_regs data=%h eop=%b flow=%h exp=0", o_data, o_eop, o_flow); end
        total++; if (o_drop_count !== '0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", o_drop_count); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        tick();
        total++; if (o_valid !== 2'b00) begin bad++; $display("FAIL reset_ignore got=%b exp=00", o_valid); end
        reset = 1'b0;
        drive(1'b0, 4'd0, '0, 1'b0, 2'b11);
        tick();
    endtask

    task automatic test_unicast();
        drive(1'b1, 4'd0, 32'hA, 1'b0, 2'b11);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL uni_ready got=%b exp=1", o_ready); end
        tick();
        total++; if (o_valid !== 2'b01 || o_data[31:0] !== 32'hA) begin
            bad++; $display("FAIL uni_beatA valid=%b data=%h exp=01/a", o_valid, o_data[31:0]); end
        drive(1'b1, 4'd0, 32'hB, 1'b0, 2'b11);
        tick();
        total++; if (o_valid !== 2'b01 || o_data[31:0] !== 32'hB) begin
            bad++; $display("FAIL uni_beatB valid=%b data=%h exp=01/b", o_valid, o_data[31:0]); end
        drive(1'b0, 4'd0, '0, 1'b0, 2'b11);
        tick();
        total++; if (o_valid !== 2'b00) begin bad++; $display("FAIL uni_idle got=%b exp=00", o_valid); end
    endtask

    task automatic test_multicast();
        drive(1'b1, 4'd2, 32'h5, 1'b0, 2'b01);
        tick();
        total++; if (o_valid !== 2'b11 || o_data !== {32'h5, 32'h5}) begin
            bad++; $display("FAIL mc_fork valid=%b data=%h exp=11/5,5", o_valid, o_data); end
        drive(1'b1, 4'd2, 32'h6, 1'b0, 2'b01);
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL mc_block got=%b exp=0", o_ready); end
        tick();
        total++; if (o_valid !== 2'b10 || o_data[63:32] !== 32'h5) begin
            bad++; $display("FAIL mc_hold valid=%b d1=%h exp=10/5", o_valid, o_data[63:32]); end
        drive(1'b1, 4'd0, 32'h7, 1'b0, 2'b01);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mc_free got=%b exp=1", o_ready); end
        tick();
        total++; if (o_valid !== 2'b11 || o_data !== {32'h5, 32'h7}) begin
            bad++; $display("FAIL mc_indep valid=%b data=%h exp=11/5,7", o_valid, o_data); end
        drive(1'b0, 4'd0, '0, 1'b0, 2'b11);
        tick();
        total++; if (o_valid !== 2'b00) begin bad++; $display("FAIL mc_drain got=%b exp=00", o_valid); end
    endtask

    task automatic test_drain_refill();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'd0, 32'h100 + i, 1'b0, 2'b11);
            total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL dr_ready beat=%0d got=%b exp=1", i, o_ready); end
            tick();
            total++; if (o_valid !== 2'b01 || o_data[31:0] !== 32'h100 + i) begin
                bad++; $display("FAIL dr_beat beat=%0d valid=%b data=%h exp=01/%h", i, o_valid, o_data[31:0], 32'h100 + i); end
        end
        drive(1'b0, 4'd0, '0, 1'b0, 2'b11);
        tick();
    endtask

    task automatic test_unmatched();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'hF, 32'hBAD0 + i, 1'b0, 2'b00);
            total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL um_ready beat=%0d got=%b exp=1", i, o_ready); end
            tick();
            total++; if (o_valid !== 2'b00) begin bad++; $display("FAIL um_valid beat=%0d got=%b exp=00", i, o_valid); end
            if (i == 2 || i == 4) begin
                total++; if (o_drop_count !== exp_drops()) begin
                    bad++; $display("FAIL um_count after=%0d got=%0d exp=%0d", i + 1, o_drop_count, exp_drops()); end
            end
        end
        drive(1'b0, 4'd0, '0, 1'b0, 2'b11);
    endtask

    task automatic test_eop();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd2, 32'hE0 + i, (i == 2), 2'b11);
            tick();
            total++; if (o_valid !== 2'b11 || o_eop !== ((i == 2) ? 2'b11 : 2'b00)) begin
                bad++; $display("FAIL eop beat=%0d valid=%b eop=%b", i, o_valid, o_eop); end
        end
        drive(1'b0, 4'd0, '0, 1'b0, 2'b11);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 4'd2, 32'h77, 1'b1, 2'b00);
        tick();
        drive(1'b0, 4'd0, '0, 1'b0, 2'b00);
        total++; if (o_valid !== 2'b11) begin bad++; $display("FAIL ar_full got=%b exp=11", o_valid); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (o_valid !== 2'b00) begin bad++; $display("FAIL ar_immediate got=%b exp=00", o_valid); end
        for (int k = 0; k < NO; k++) q[k].delete();
        drops = 0;
        drive(1'b1, 4'd2, 32'h99, 1'b0, 2'b11);
        tick();
        reset = 1'b0;
        drive(1'b0, 4'd0, '0, 1'b0, 2'b11);
        tick();
        total++; if (o_valid !== 2'b00) begin bad++; $display("FAIL ar_release got=%b exp=00", o_valid); end
        drive(1'b1, 4'd1, 32'h42, 1'b0, 2'b11);
        tick();
        total++; if (o_valid !== 2'b10 || o_data[63:32] !== 32'h42 || o_flow[7:4] !== 4'd1) begin
            bad++; $display("FAIL ar_next valid=%b d1=%h f1=%h exp=10/42/1", o_valid, o_data[63:32], o_flow[7:4]); end
        drive(1'b0, 4'd0, '0, 1'b0, 2'b11);
        tick();
    endtask

    task automatic test_random();
        logic [WF-1:0] flows_pick[4];
        flows_pick[0] = 4'd0; flows_pick[1] = 4'd1; flows_pick[2] = 4'd2; flows_pick[3] = 4'hF;
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), flows_pick[$urandom_range(0, 3)], $urandom,
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            total++; if (o_ready !== exp_ready()) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, o_ready, exp_ready()); end
            total++; if (o_valid !== exp_valid()) begin
                bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, o_valid, exp_valid()); end
            for (int k = 0; k < NO; k++) begin
                if (q[k].size() != 0) begin
                    total++;
                    if (o_data[k*WO +: WO] !== q[k][0].d || o_eop[k] !== q[k][0].e || o_flow[k*WF +: WF] !== q[k][0].f) begin
                        bad++; $display("FAIL rnd_beat cyc=%0d out=%0d got=%h/%b/%h exp=%h/%b/%h", n, k,
                            o_data[k*WO +: WO], o_eop[k], o_flow[k*WF +: WF], q[k][0].d, q[k][0].e, q[k][0].f);
                    end
                end
            end
            tick();
        end
        drive(1'b0, 4'd0, '0, 1'b0, 2'b11);
        total++; if (o_drop_count !== exp_drops()) begin
            bad++; $display("FAIL rnd_drops got=%0d exp=%0d", o_drop_count, exp_drops()); end
    endtask

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_flow  = '0;
        i_data  = '0;
        i_eop   = 1'b0;
        i_ready = '0;
        #1;
        test_reset();
        test_unicast();
        test_multicast();
        test_drain_refill();
        test_unmatched();
        test_eop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ct_split_buf
`default_nettype wire

// File: doc/ct_split_buf.md
Name: ct_split_buf

Overview:
- Next-generation flow-routed split node. Each incoming beat is steered by its flow ID to one output or to several (multicast).
- Every output has its own 1-deep registered stage, so a multicast beat is delivered eagerly: each output drains on its own timing, and stalled outputs do not block outputs that are ready.
- Adds packet end-marker pass-through and explicit handling of beats whose flow ID is unknown.
- Sits in the same interconnect fabric as the existing split/merge nodes. Drop-in where a registered split boundary is needed for timing.

Parameters:
- NO, 2, number of outputs (>=1)
- WO, 32, data width
- NF, 1, number of flows registered with this node (>=1)
- WF, 4, flow_id width
- FLOWS, 0, NF*WF vector; slice i holds the flow_id of flow i
- ENABLES, 0, NF*NO vector; slice i holds the bitmask of outputs targeted by flow i
- WC, 16, drop-counter width

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- i_data  in  WO  input data
- i_valid  in  1  input valid
- i_eop  in  1  end-of-packet marker for the beat
- i_flow  in  WF  input flow_id
- o_ready  out  1  input ready
- o_data  out  NO*WO  per-output data, from the output registers
- o_valid  out  NO  per-output valid
- o_eop  out  NO  per-output eop
- o_flow  out  NO*WF  per-output flow_id
- i_ready  in  NO  per-output downstream ready
- o_drop_count  out  WC  count of dropped unmatched beats (optional feature)

Behaviour:
- Clock and reset: clk, rising edge. reset is asynchronous, active-high; all state clears on assertion.
- Reset values: o_valid=0, and o_data/o_eop/o_flow registers=0. o_drop_count=0. o_ready is combinational and reads 1 during reset (no slots full), but a beat presented during reset is ignored.
- Flow lookup (combinational): en = OR over i of (ENABLES slice i AND all-ones when FLOWS slice i == i_flow).
  - Duplicate flow IDs in FLOWS OR together.
  - match = (en != 0).
- Slot state: full[k] is the same register as o_valid[k].
- Ready: o_ready = AND over k of (!en[k] | !full[k] | i_ready[k]).
  - o_ready is combinational from i_ready and i_flow (ready pass-through), with no combinational path from i_valid.
- Accept: acc = i_valid & o_ready.
- Per-output update each cycle, first matching rule wins:
  - acc & en[k]: load data/eop/flow into slot k and set full[k]=1. This covers the simultaneous drain+refill case (back-to-back throughput of 1 beat/cycle).
  - full[k] & i_ready[k]: full[k]=0.
  - otherwise hold. While o_valid=1, data/eop/flow must stay stable until the transfer completes.
- Latency: 1 cycle from accept to o_valid on every enabled output.
- Eager fork: an accepted multicast beat occupies each enabled slot independently. The next beat is accepted once every slot it targets is empty or draining this cycle. Slots it does not target are irrelevant.
- Unmatched flow (en==0): o_ready=1, the beat is consumed and dropped, no slot changes, and the drop counter increments.
- Ordering: per-output beat order equals input order. No reordering, and packet beats are not interleaved per output.
- Reset mid-operation: buffered beats are discarded, with no partial outputs afterwards.

Optional Feature:
- Macro: CT_SPLIT_BUF_DROP_COUNT_EN.
- Defined: o_drop_count increments by 1 on each acc with en==0, saturates at all-ones, and resets to 0.
- Undefined: o_drop_count is tied to 0, no counter logic is generated, and drop behaviour is otherwise identical.

Decomposition:
- Shared package ct_pkg holds:
  - the flow-lookup function (FLOWS, ENABLES, i_flow -> mask)
  - the default widths WF/WO
- Sub-module ct_out_slot: one per output, generated NO times. It holds the 1-deep register with load/drain and exposes full/empty.
- The top level contains the lookup, the ready AND-reduction, and the drop counter.

Test Plan:
- Unicast: NO=2, FLOWS={1,0}, ENABLES={2'b10,2'b01}. Send flow 0 beats 0xA,0xB back-to-back with all i_ready=1 -> output 0 shows 0xA then 0xB on consecutive cycles 1 cycle after accept; o_valid[1] stays 0.
- Eager multicast: flow 2 targets 2'b11, i_ready=2'b01 for 3 cycles -> output 0 takes beat 0x5 in cycle 1. Output 1 holds o_valid=1 with 0x5 until i_ready[1] rises. o_ready=0 for a second flow-2 beat while slot 1 is full and stalled, and o_ready=1 for a flow-0 beat (output 0 free).
- Drain+refill: slot full and i_ready=1 while a new beat is accepted -> o_valid stays 1 and data changes to the new beat the next cycle; 1 beat/cycle sustained over 8 beats.
- Unmatched flow 0xF, 3 beats -> o_ready=1, no o_valid, o_drop_count=3 with macro and 0 without. With WC=2 and 5 drops -> saturates at 3.
- Async reset while both slots are full -> o_valid=2'b00 immediately, no valid on release, and the next beat is delivered normally.
- eop pass-through: 3-beat packet with eop on beat 3 -> o_eop=1 only alongside beat 3 on each enabled output.
